// File: rtl/rca_wb_serializer.sv
// Writeback serializer for RCA result bundles. Bundles are queued in a small
// FIFO and drained one register write per cycle, followed by a completion pulse.
module rca_wb_serializer #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned ID_W            = 3,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ID_W-1:0]                   in_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0]   in_rd,
  input  logic [NUM_WRITE_PORTS*5-1:0]      in_rd_addr,
  input  logic [NUM_WRITE_PORTS-1:0]        in_wr_mask,
  output logic                              wb_valid,
  input  logic                              wb_ack,
  output logic [4:0]                        wb_rd_addr,
  output logic [XLEN-1:0]                   wb_data,
  output logic [ID_W-1:0]                   wb_id,
  output logic                              wb_last,
  output logic                              done_valid,
  output logic [ID_W-1:0]                   done_id,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned OccW  = $clog2(DEPTH+1);
  localparam int unsigned PortW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  typedef enum logic [1:0] {StIdle, StDrain, StRetire} state_e;

  // Bundle storage
  logic [ID_W-1:0]                 id_q   [DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] data_q [DEPTH];
  logic [NUM_WRITE_PORTS*5-1:0]    addr_q [DEPTH];
  logic [NUM_WRITE_PORTS-1:0]      mask_q [DEPTH];

  state_e                     state_q, state_d;
  logic [PortW-1:0]           port_q, port_d;
  logic [NUM_WRITE_PORTS-1:0] rem_q, rem_d;
  logic [PtrW-1:0]            head_q, tail_q;
  logic [OccW-1:0]            occ_q;

  logic                       enq, pop;
  logic [NUM_WRITE_PORTS-1:0] enq_mask, head_mask, port_bit, rem_left;

  function automatic logic [PortW-1:0] lowest(input logic [NUM_WRITE_PORTS-1:0] m);
    logic [PortW-1:0] idx;
    idx = '0;
    for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
      if (m[i]) idx = PortW'(i);
    end
    return idx;
  endfunction

  // Registered occupancy only, so there is no in_valid -> in_ready path
  assign in_ready  = (occ_q < OccW'(DEPTH));
  assign occupancy = occ_q;
  assign enq       = in_valid && in_ready;
  assign head_mask = mask_q[head_q];
  assign port_bit  = NUM_WRITE_PORTS'(1) << port_q;
  assign rem_left  = rem_q & ~port_bit;

  // Writes to x0 are dropped here so the drain logic never sees them
  always_comb begin
    enq_mask = '0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      enq_mask[i] = in_wr_mask[i] && (in_rd_addr[i*5 +: 5] != 5'd0);
    end
  end

  // FIFO payload write at tail; no reset needed, validity is tracked by occupancy
  always_ff @(posedge clk) begin
    if (enq) begin
      id_q[tail_q]   <= in_id;
      data_q[tail_q] <= in_rd;
      addr_q[tail_q] <= in_rd_addr;
      mask_q[tail_q] <= enq_mask;
    end
  end

  // Output FSM next-state and outputs
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    rem_d      = rem_q;
    pop        = 1'b0;
    wb_valid   = 1'b0;
    wb_rd_addr = '0;
    wb_data    = '0;
    wb_id      = '0;
    wb_last    = 1'b0;
    done_valid = 1'b0;
    done_id    = '0;
    unique case (state_q)
      StIdle: begin
        if (occ_q != '0) begin
          if (head_mask != '0) begin
            state_d = StDrain;
            rem_d   = head_mask;
            port_d  = lowest(head_mask);
          end else begin
            state_d = StRetire;
          end
        end
      end
      StDrain: begin
        wb_valid   = 1'b1;
        wb_rd_addr = addr_q[head_q][port_q*5 +: 5];
        wb_data    = data_q[head_q][port_q*XLEN +: XLEN];
        wb_id      = id_q[head_q];
        wb_last    = (rem_left == '0);
        if (wb_ack) begin
          rem_d = rem_left;
          if (rem_left != '0) begin
            port_d = lowest(rem_left);
          end else begin
            state_d = StRetire;
          end
        end
      end
      StRetire: begin
        done_valid = 1'b1;
        done_id    = id_q[head_q];
        pop        = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      port_q  <= '0;
      rem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rem_q   <= rem_d;
      if (enq) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      occ_q <= occ_q + OccW'(enq) - OccW'(pop);
    end
  end

endmodule

// File: tb/tb_rca_wb_serializer.sv
// Directed self-checking bench for rca_wb_serializer.
module tb_rca_wb_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_id;
  logic [63:0] in_rd;
  logic [9:0]  in_rd_addr;
  logic [1:0]  in_wr_mask;
  logic        wb_valid;
  logic        wb_ack;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic [2:0]  wb_id;
  logic        wb_last;
  logic        done_valid;
  logic [2:0]  done_id;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wq[$];
  logic [2:0]  dq[$];

  rca_wb_serializer #(
    .XLEN(32), .NUM_WRITE_PORTS(2), .ID_W(3), .DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_id      (in_id),
    .in_rd      (in_rd),
    .in_rd_addr (in_rd_addr),
    .in_wr_mask (in_wr_mask),
    .wb_valid   (wb_valid),
    .wb_ack     (wb_ack),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .wb_id      (wb_id),
    .wb_last    (wb_last),
    .done_valid (done_valid),
    .done_id    (done_id),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor of accepted writes and completions
  always @(negedge clk) begin
    if (wb_valid && wb_ack) wq.push_back(wb_data);
    if (done_valid) dq.push_back(done_id);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] m);
    in_valid   = 1'b1;
    in_id      = id;
    in_rd      = {d1, d0};
    in_rd_addr = {a1, a0};
    in_wr_mask = m;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic wait_done_count(input int n, input string tag);
    int cnt;
    cnt = 0;
    while (dq.size() < n && cnt < 60) begin
      tick();
      cnt++;
    end
    if (cnt >= 60) check_eq(tag, 64'(dq.size()), 64'(n));
  endtask

  task automatic wait_empty(input string tag);
    int cnt;
    cnt = 0;
    while (occupancy != 3'd0 && cnt < 60) begin
      tick();
      cnt++;
    end
    check_eq(tag, 64'(occupancy), 64'd0);
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_id      = '0;
    in_rd      = '0;
    in_rd_addr = '0;
    in_wr_mask = '0;
    wb_ack     = 1'b1;
    #3;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_done_valid", 64'(done_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Two-write bundle
    push(3'd5, 32'hA, 32'hB, 5'd3, 5'd7, 2'b11);
    check_eq("t1_t1_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("t1_t1_occ", 64'(occupancy), 64'd1);
    tick();
    check_eq("t1_w0_valid", 64'(wb_valid), 64'd1);
    check_eq("t1_w0_addr", 64'(wb_rd_addr), 64'd3);
    check_eq("t1_w0_data", 64'(wb_data), 64'hA);
    check_eq("t1_w0_last", 64'(wb_last), 64'd0);
    check_eq("t1_w0_id", 64'(wb_id), 64'd5);
    tick();
    check_eq("t1_w1_addr", 64'(wb_rd_addr), 64'd7);
    check_eq("t1_w1_data", 64'(wb_data), 64'hB);
    check_eq("t1_w1_last", 64'(wb_last), 64'd1);
    check_eq("t1_w1_done", 64'(done_valid), 64'd0);
    tick();
    check_eq("t1_done_valid", 64'(done_valid), 64'd1);
    check_eq("t1_done_id", 64'(done_id), 64'd5);
    check_eq("t1_done_wbv", 64'(wb_valid), 64'd0);
    tick();
    check_eq("t1_after_done", 64'(done_valid), 64'd0);
    check_eq("t1_after_occ", 64'(occupancy), 64'd0);

    // Masked writes: empty mask, then a write to x0
    push(3'd2, 32'h1, 32'h2, 5'd4, 5'd5, 2'b00);
    check_eq("t2a_t1_done", 64'(done_valid), 64'd0);
    tick();
    check_eq("t2a_done_valid", 64'(done_valid), 64'd1);
    check_eq("t2a_done_id", 64'(done_id), 64'd2);
    check_eq("t2a_wb_valid", 64'(wb_valid), 64'd0);
    tick();
    push(3'd3, 32'h9, 32'h0, 5'd0, 5'd0, 2'b01);
    check_eq("t2b_t1_wbv", 64'(wb_valid), 64'd0);
    tick();
    check_eq("t2b_done_valid", 64'(done_valid), 64'd1);
    check_eq("t2b_done_id", 64'(done_id), 64'd3);
    check_eq("t2b_wb_valid", 64'(wb_valid), 64'd0);
    tick();

    // Backpressure on the first write
    wb_ack = 1'b0;
    push(3'd1, 32'h11, 32'h22, 5'd4, 5'd9, 2'b11);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_valid", 64'(wb_valid), 64'd1);
      check_eq("t3_hold_addr", 64'(wb_rd_addr), 64'd4);
      check_eq("t3_hold_data", 64'(wb_data), 64'h11);
      check_eq("t3_hold_last", 64'(wb_last), 64'd0);
      check_eq("t3_hold_done", 64'(done_valid), 64'd0);
      tick();
    end
    wb_ack = 1'b1;
    check_eq("t3_rel_addr", 64'(wb_rd_addr), 64'd4);
    tick();
    check_eq("t3_w1_addr", 64'(wb_rd_addr), 64'd9);
    check_eq("t3_w1_data", 64'(wb_data), 64'h22);
    check_eq("t3_w1_done", 64'(done_valid), 64'd0);
    tick();
    check_eq("t3_done_valid", 64'(done_valid), 64'd1);
    check_eq("t3_done_id", 64'(done_id), 64'd1);
    tick();

    // Fill to DEPTH with ack low, illegal fifth offer, then drain in order
    wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(3'(i), 32'h100 + 32'(i), 32'h0, 5'(i + 1), 5'd0, 2'b01);
    end
    check_eq("t4_full_occ", 64'(occupancy), 64'd4);
    check_eq("t4_full_ready", 64'(in_ready), 64'd0);
    push(3'd7, 32'hDEAD, 32'h0, 5'd1, 5'd0, 2'b01);
    check_eq("t4_ignored_occ", 64'(occupancy), 64'd4);
    check_eq("t4_head_data", 64'(wb_data), 64'h100);
    wq.delete();
    dq.delete();
    wb_ack = 1'b1;
    tick();
    check_eq("t4_first_done", 64'(done_valid), 64'd1);
    check_eq("t4_first_done_id", 64'(done_id), 64'd0);
    check_eq("t4_ready_during_pop", 64'(in_ready), 64'd0);
    tick();
    check_eq("t4_ready_after_pop", 64'(in_ready), 64'd1);
    check_eq("t4_occ_after_pop", 64'(occupancy), 64'd3);
    wait_done_count(4, "t4_timeout");
    repeat (4) tick();
    check_eq("t4_done_count", 64'(dq.size()), 64'd4);
    for (int i = 0; i < 4 && i < dq.size(); i++) check_eq("t4_done_order", 64'(dq[i]), 64'(i));
    check_eq("t4_write_count", 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) check_eq("t4_write_data", 64'(wq[i]), 64'h100 + 64'(i));
    check_eq("t4_empty_occ", 64'(occupancy), 64'd0);

    // Second pass through wrapped pointers
    wq.delete();
    dq.delete();
    for (int i = 4; i < 8; i++) begin
      push(3'(i), 32'h0, 32'h200 + 32'(i), 5'd0, 5'(i + 10), 2'b10);
    end
    wait_done_count(4, "t4w_timeout");
    check_eq("t4w_done_count", 64'(dq.size()), 64'd4);
    for (int i = 0; i < 4 && i < dq.size(); i++) check_eq("t4w_done_order", 64'(dq[i]), 64'(i + 4));
    for (int i = 0; i < 4 && i < wq.size(); i++) check_eq("t4w_write_data", 64'(wq[i]), 64'h204 + 64'(i));
    wait_empty("t4w_empty");
    check_eq("t4w_ready", 64'(in_ready), 64'd1);

    // Enqueue in the RETIRE cycle at occupancy 2
    push(3'd1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00);
    push(3'd2, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00);
    check_eq("t5_retire", 64'(done_valid), 64'd1);
    check_eq("t5_retire_id", 64'(done_id), 64'd1);
    check_eq("t5_occ_before", 64'(occupancy), 64'd2);
    push(3'd3, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00);
    check_eq("t5_occ_after", 64'(occupancy), 64'd2);
    wait_empty("t5_empty");

    // Asynchronous reset mid-drain
    wb_ack = 1'b0;
    push(3'd4, 32'h77, 32'h88, 5'd2, 5'd6, 2'b11);
    tick();
    check_eq("t6_pre_wbv", 64'(wb_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_wbv", 64'(wb_valid), 64'd0);
    check_eq("t6_rst_occ", 64'(occupancy), 64'd0);
    check_eq("t6_rst_ready", 64'(in_ready), 64'd1);
    check_eq("t6_rst_data", 64'(wb_data), 64'd0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    wb_ack = 1'b1;
    dq.delete();
    push(3'd6, 32'h55, 32'h0, 5'd5, 5'd0, 2'b01);
    tick();
    check_eq("t6_new_wbv", 64'(wb_valid), 64'd1);
    check_eq("t6_new_addr", 64'(wb_rd_addr), 64'd5);
    check_eq("t6_new_data", 64'(wb_data), 64'h55);
    check_eq("t6_new_last", 64'(wb_last), 64'd1);
    tick();
    check_eq("t6_new_done", 64'(done_valid), 64'd1);
    check_eq("t6_new_done_id", 64'(done_id), 64'd6);
    tick();
    check_eq("t6_done_count", 64'(dq.size()), 64'd1);
    check_eq("t6_final_occ", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_wb_serializer.md
# rca_wb_serializer

Downstream writeback stage for the RCA unit. Accepts one completed RCA result bundle per handshake: an instruction ID plus up to NUM_WRITE_PORTS destination values with register addresses. Buffers bundles in a small FIFO and drains them one register write per cycle into the CPU's single-port register-file writeback path. After the last write of each bundle, it issues a per-instruction completion pulse.

## Interface
Parameters:
- XLEN, 32, data width
- NUM_WRITE_PORTS, 2, result ports per RCA bundle
- ID_W, 3, instruction ID width
- DEPTH, 4, bundle FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  bundle offered (driven from the RCA done signal)
- in_ready  out  1  FIFO can accept a bundle
- in_id  in  ID_W  instruction ID of the bundle
- in_rd  in  NUM_WRITE_PORTS*XLEN  result values; port i at [i*XLEN +: XLEN]
- in_rd_addr  in  NUM_WRITE_PORTS*5  destination registers; port i at [i*5 +: 5]
- in_wr_mask  in  NUM_WRITE_PORTS  ports carrying a real result (all-zero for config instructions)
- wb_valid  out  1  register write presented
- wb_ack  in  1  register file accepts write this cycle
- wb_rd_addr  out  5  write address
- wb_data  out  XLEN  write data
- wb_id  out  ID_W  ID of the owning bundle
- wb_last  out  1  this is the bundle's final write
- done_valid  out  1  one-cycle completion pulse
- done_id  out  ID_W  ID being retired
- occupancy  out  $clog2(DEPTH+1)  bundles currently held

## Operation
- **Enqueue:** on in_valid && in_ready, write the entry at tail. Tail increments modulo DEPTH. The stored mask is in_wr_mask[i] && (in_rd_addr[i] != 0); writes to x0 are dropped at enqueue.
- **in_ready:** in_ready = (occupancy < DEPTH), using registered occupancy. A pop in the same cycle does not free a slot until the next cycle.
- **Illegal input:** in_valid while !in_ready is illegal. The bundle is ignored and no state changes.
- **Output FSM:** three states, IDLE, DRAIN, RETIRE.
  - IDLE: if occupancy != 0 and the head mask is nonzero, go to DRAIN with port pointer p = lowest set mask bit. If occupancy != 0 and the head mask is zero, go to RETIRE. Otherwise stay in IDLE.
  - DRAIN: wb_valid = 1 and presents head port p. wb_last = 1 when p is the highest remaining set bit. On wb_ack, clear bit p. If bits remain, p = next lowest set bit and stay in DRAIN; otherwise go to RETIRE. With no ack, all wb_* outputs hold stable.
  - RETIRE: done_valid = 1 with done_id = head ID. Pop the head (head increments modulo DEPTH), then go to IDLE.
- **Write order:** ports are written in ascending index order. Duplicate addresses are written twice, so the higher port wins.
- **Occupancy update:** occupancy = occupancy + enqueue − pop each cycle. Enqueue and pop in the same cycle leave occupancy unchanged.
- **Output values outside DRAIN/RETIRE:** wb_valid = 0 and done_valid = 0. wb_* and done_id are don't-care but are driven to 0.
- **Reset (asserted at any time):** immediately sets state = IDLE, head = tail = 0, occupancy = 0, and all outputs to 0 except in_ready, which resets to 1. In-flight bundles are discarded.

## Timing
- Bundle accepted in cycle T:
  - Earliest first wb_valid is T+2 (IDLE samples occupancy in T+1).
  - Earliest done_valid for an empty mask is T+2.
- Final wb_ack in cycle A produces done_valid in A+1.
- Per-bundle cost with k writes and wb_ack held high: 1 (IDLE) + k (DRAIN) + 1 (RETIRE) cycles.
- No combinational path from in_valid to in_ready. wb_ack affects only next-state logic.
- Pointer wrap: DEPTH consecutive enqueues followed by DEPTH pops return head = tail = 0 with occupancy = 0.

## Test plan
- **Two-write bundle:** single bundle id=5, mask=2'b11, addrs 3/7, data 0xA/0xB, wb_ack held 1. Required response: writes (3,0xA,last=0) then (7,0xB,last=1), then done_valid with id=5, first write 2 cycles after accept.
- **Masked writes:** bundle with mask=2'b00 (config instr), id=2, gives done_valid id=2 at T+2 with no wb_valid. Bundle with mask=2'b01 and addr 0 also gives done only.
- **Backpressure:** wb_ack held 0 for 5 cycles on the first write. Required response: wb_* stable throughout, then it proceeds. No done_valid before the last ack.
- **Fill and wrap:** enqueue DEPTH=4 bundles with ack low. Required response: in_ready = 0 and occupancy = 4; a 5th in_valid is ignored. Then release ack. Required response: the four bundles retire in ID order, in_ready reasserts the cycle after the first pop, and a further 4 bundles wrap the pointers correctly.
- **Simultaneous enqueue and pop:** enqueue in the same cycle as RETIRE at occupancy 2. Required response: occupancy stays 2.
- **Reset mid-drain:** reset asserted mid-DRAIN (asynchronous, between clock edges). Required response: wb_valid drops immediately, occupancy = 0, and in_ready = 1. After release, a new bundle drains normally.
